// File: rtl/polaris_bus_pkg.sv
// Shared bus definitions for the polaris master port: request size encodings,
// halfword bridge state encoding and the address width.
package polaris_bus_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    SIZE_NONE    = 2'b00,
    SIZE_BYTE    = 2'b01,
    SIZE_HALF    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    B0   = 2'b01,
    B1   = 2'b10,
    ACK  = 2'b11
  } bridge_state_e;

  // True for sizes that start a transfer; SIZE_ILLEGAL is silently ignored.
  function automatic logic is_xfer_size(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

endpackage

// File: rtl/bridge_timer.sv
// Per-phase wait counter for halfword_bridge. Only compiled when
// HALFWORD_BRIDGE_TIMEOUT_EN is defined; the default build has no timer.
`ifdef HALFWORD_BRIDGE_TIMEOUT_EN
module bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Count wait cycles of the current byte phase; cleared between phases.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Fires on the wait cycle that would make the count reach TIMEOUT_CYCLES.
  assign expired_o = inc_i && (cnt_q == Limit);

endmodule
`endif

// File: rtl/halfword_bridge.sv
// 16-bit size-encoded master port to 8-bit external memory bus bridge.
// Each request becomes one or two byte phases, assembled little-endian.
// Optional phase timeout with bus error: define HALFWORD_BRIDGE_TIMEOUT_EN.
module halfword_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [63:0] adr_i,
  input  logic [1:0]  size_i,
  input  logic        we_i,
  input  logic [15:0] dat_i,
  input  logic        vpa_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [63:0] xadr_o,
  output logic [7:0]  xdat_o,
  input  logic [7:0]  xdat_i,
  output logic        xstb_o,
  output logic        xwe_o,
  output logic        xvpa_o,
  input  logic        xack_i
);
  import polaris_bus_pkg::*;

  bridge_state_e   state_q;
  logic [XLEN-1:0] adr_q;
  size_e           size_q;
  logic            we_q;
  logic [15:0]     dat_q;
  logic            vpa_q;
  logic [7:0]      lo_q, hi_q;

  logic [15:0]     rdat_q;
  logic            ack_q, err_q;
  logic [XLEN-1:0] xadr_q;
  logic [7:0]      xdat_q;
  logic            xstb_q, xwe_q, xvpa_q;

  logic            in_phase;
  logic            timeout;
  logic [15:0]     rd_data;

  assign in_phase = (state_q == B0) || (state_q == B1);

`ifdef HALFWORD_BRIDGE_TIMEOUT_EN
  logic timer_clr, timer_inc;

  // Counter restarts whenever we are not waiting inside a byte phase.
  assign timer_clr = !in_phase || xack_i;
  assign timer_inc = in_phase && !xack_i;

  bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (timer_clr),
    .inc_i    (timer_inc),
    .expired_o(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Read data presented in ACK: B1 completion is always a halfword, a B0 completion a byte.
  always_comb begin
    rd_data = '0;
    if (xack_i && !we_q) begin
      if (size_q == SIZE_HALF) begin
        rd_data = {xdat_i, lo_q};
      end else begin
        rd_data = {8'h00, xdat_i};
      end
    end
  end

  // Transfer FSM with registered master and external bus outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      adr_q   <= '0;
      size_q  <= SIZE_NONE;
      we_q    <= 1'b0;
      dat_q   <= '0;
      vpa_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      xadr_q  <= '0;
      xdat_q  <= '0;
      xstb_q  <= 1'b0;
      xwe_q   <= 1'b0;
      xvpa_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (is_xfer_size(size_i)) begin
            adr_q   <= adr_i;
            size_q  <= size_e'(size_i);
            we_q    <= we_i;
            dat_q   <= dat_i;
            vpa_q   <= vpa_i;
            xstb_q  <= 1'b1;
            xadr_q  <= adr_i;
            xwe_q   <= we_i;
            xdat_q  <= dat_i[7:0];
            xvpa_q  <= vpa_i;
            state_q <= B0;
          end
        end
        B0, B1: begin
          if (xack_i || timeout) begin
            if (xack_i && !we_q) begin
              if (state_q == B0) lo_q <= xdat_i;
              else               hi_q <= xdat_i;
            end
            if (xack_i && (state_q == B0) && (size_q == SIZE_HALF)) begin
              xadr_q  <= adr_q + XLEN'(1);
              xdat_q  <= dat_q[15:8];
              state_q <= B1;
            end else begin
              // A timeout completes with err and zero data (rd_data is 0 without xack_i).
              ack_q   <= 1'b1;
              err_q   <= !xack_i;
              rdat_q  <= rd_data;
              xstb_q  <= 1'b0;
              xadr_q  <= '0;
              xdat_q  <= '0;
              xwe_q   <= 1'b0;
              xvpa_q  <= 1'b0;
              state_q <= ACK;
            end
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dat_o  = rdat_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign xadr_o = xadr_q;
  assign xdat_o = xdat_q;
  assign xstb_o = xstb_q;
  assign xwe_o  = xwe_q;
  assign xvpa_o = xvpa_q;

  logic [7:0] unused_hi;
  assign unused_hi = hi_q;

endmodule
